// File: rtl/framebuffer_memory.sv
// Purpose  : 640x480x24 frame store, one write port and one read port, block-RAM style.
// Latency  : read data registered, out0 valid one clock after read0 is sampled; writes land on the edge.
// Backpress: none -- one write and one read accepted every cycle, no busy/ready.
//
// Ports:
//   clk      system clock, all storage updates on the rising edge
//   rst      asynchronous active-high reset (clears out0 only, frame contents kept)
//   read0    linear read address (y*H_RES + x)
//   out0     registered read data, RGB 8:8:8 with red in [23:16]
//   writing  write enable
//   waddr    linear write address
//   wdata    write data
module framebuffer_memory #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read0,
  output logic [DATA_W-1:0] out0,
  input  logic              writing,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  // Frame size is fixed by the raster geometry; ADDR_W must cover it.
  localparam int DEPTH = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // No reset on the array so it maps onto block RAM; the declaration
  // initialiser gives the all-black power-up frame.
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic rd_in_range;
  logic wr_ok;

  // The address space is a power of two but the frame is not: anything past
  // the last pixel is outside the store and must neither alias nor read back.
  assign rd_in_range = (read0 <= LAST_ADDR);

  // Writes are gated off while rst is high so a rasteriser still running
  // during reset cannot disturb the retained frame.
  assign wr_ok = writing && !rst && (waddr <= LAST_ADDR);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-first: this sees the pre-edge array contents, so a same-address
  // write in the same cycle returns the old pixel and the new one a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0 <= '0;
    end else if (rd_in_range) begin
      out0 <= mem[read0];
    end else begin
      out0 <= '0;
    end
  end

endmodule

// File: tb/tb_framebuffer_memory.sv
module tb_framebuffer_memory;
  localparam int AW    = 19;
  localparam int DW    = 24;
  localparam int DEPTH = 640 * 480;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] read0 = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          writing = 1'b0;
  logic [DW-1:0] out0;

  int total = 0;
  int bad   = 0;

  // Reference contents: only locations the bench has written; everything else is black.
  logic [DW-1:0] model [int];

  typedef struct {
    string         name;
    bit            wr;
    int            wa;
    logic [DW-1:0] wd;
    int            ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  framebuffer_memory dut (
    .clk    (clk),
    .rst    (rst),
    .read0  (read0),
    .out0   (out0),
    .writing(writing),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  function automatic vec_t mk(string name, bit wr, int wa, logic [DW-1:0] wd,
                              int ra, logic [DW-1:0] exp);
    vec_t v;
    v.name = name; v.wr = wr; v.wa = wa; v.wd = wd; v.ra = ra; v.exp = exp;
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_px(int a);
    if (a >= DEPTH) return '0;
    if (model.exists(a)) return model[a];
    return '0;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out0=%06h expected=%06h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: present inputs, take the edge, return 1ns after it.
  task automatic cyc(bit wr, int wa, logic [DW-1:0] wd, int ra);
    writing = wr;
    waddr   = AW'(wa);
    wdata   = wd;
    read0   = AW'(ra);
    @(posedge clk);
    #1;
    if (wr && !rst && wa < DEPTH) model[wa] = wd;
    writing = 1'b0;
  endtask

  initial begin : main
    int errs;
    int reds;
    int first_bad;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out0", out0, 24'h000000);
    rst = 1'b0;

    vt.push_back(mk("pwr_rd_0",        0, 0,      24'h0,      0,      24'h000000));
    vt.push_back(mk("pwr_rd_121870",   0, 0,      24'h0,      121870, 24'h000000));
    vt.push_back(mk("pwr_rd_307199",   0, 0,      24'h0,      307199, 24'h000000));
    vt.push_back(mk("wr_121870_rd_nb", 1, 121870, 24'hff0000, 121869, 24'h000000));
    vt.push_back(mk("rd_121870",       0, 0,      24'h0,      121870, 24'hff0000));
    vt.push_back(mk("rd_121869",       0, 0,      24'h0,      121869, 24'h000000));
    vt.push_back(mk("preload_5",       1, 5,      24'h00ff00, 0,      24'h000000));
    vt.push_back(mk("collide_5_old",   1, 5,      24'h0000ff, 5,      24'h00ff00));
    vt.push_back(mk("collide_5_new",   0, 0,      24'h0,      5,      24'h0000ff));
    vt.push_back(mk("indep_wr10_rd5",  1, 10,     24'h123abc, 5,      24'h0000ff));
    vt.push_back(mk("rd_10",           0, 0,      24'h0,      10,     24'h123abc));
    vt.push_back(mk("wr_last",         1, 307199, 24'habcdef, 0,      24'h000000));
    vt.push_back(mk("oor_wr_rd",       1, 307200, 24'h123456, 307200, 24'h000000));
    vt.push_back(mk("oor_rd_0",        0, 0,      24'h0,      0,      24'h000000));
    vt.push_back(mk("oor_rd_last",     0, 0,      24'h0,      307199, 24'habcdef));
    vt.push_back(mk("oor_rd_307200",   0, 0,      24'h0,      307200, 24'h000000));
    vt.push_back(mk("oor_rd_max",      0, 0,      24'h0,      524287, 24'h000000));
    vt.push_back(mk("rd_121870_again", 0, 0,      24'h0,      121870, 24'hff0000));

    foreach (vt[i]) begin
      cyc(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].ra);
      check(vt[i].name, out0, vt[i].exp);
    end

    // Square x 270..369, y 190..289, read port parked on 0 meanwhile.
    for (int y = 190; y < 290; y++)
      for (int x = 270; x < 370; x++)
        cyc(1, y * 640 + x, 24'hff0000, 0);

    // Hand-picked boundary pixels
    cyc(0, 0, 0, 121869);          check("sq_before_first", out0, 24'h000000);
    cyc(0, 0, 0, 121870);          check("sq_first",        out0, 24'hff0000);
    cyc(0, 0, 0, 185329);          check("sq_last",         out0, 24'hff0000);
    cyc(0, 0, 0, 185330);          check("sq_after_last",   out0, 24'h000000);
    cyc(0, 0, 0, 190 * 640 + 370); check("sq_right_edge",   out0, 24'h000000);
    cyc(0, 0, 0, 289 * 640 + 270); check("sq_bottom_left",  out0, 24'hff0000);
    cyc(0, 0, 0, 290 * 640 + 270); check("sq_below",        out0, 24'h000000);

    // Raster scan of a window one-plus pixels wider than the square on every side.
    errs = 0;
    reds = 0;
    first_bad = -1;
    for (int y = 188; y < 292; y++) begin
      for (int x = 266; x < 374; x++) begin
        logic [DW-1:0] e;
        e = ref_px(y * 640 + x);
        cyc(0, 0, 0, y * 640 + x);
        if (out0 === 24'hff0000) reds++;
        if (out0 !== e) begin
          errs++;
          if (first_bad < 0) first_bad = y * 640 + x;
        end
      end
    end
    check_int("scan_mismatches", errs, 0);
    check_int("scan_red_count", reds, 10000);
    if (errs != 0) $display("first scan mismatch at addr %0d", first_bad);

    // Reset mid-operation
    cyc(0, 0, 0, 121870);
    check("pre_rst_red", out0, 24'hff0000);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_clear", out0, 24'h000000);
    writing = 1'b1;
    waddr   = AW'(121870);
    wdata   = 24'h000001;
    @(posedge clk);
    #1;
    check("rst_hold_zero", out0, 24'h000000);
    writing = 1'b0;
    #2;
    rst = 1'b0;
    cyc(0, 0, 0, 121870);
    check("rst_retained", out0, 24'hff0000);
    cyc(0, 0, 0, 5);
    check("rst_retained_5", out0, 24'h0000ff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
